// File: rtl/flappy_pkg.sv
// flappy_pkg: shared screen geometry, pipe FSM states
// and the hole clamp helper.
package flappy_pkg;

  localparam int SCREEN_W  = 320;
  localparam int SCREEN_H  = 240;
  localparam int PIPE_W    = 40;
  localparam int HOLE_SIZE = 50;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_STOPPED
  } pipe_state_e;

  function automatic logic [7:0] clamp8(
    input logic [7:0] v,
    input logic [7:0] lo,
    input logic [7:0] hi
  );
    logic [7:0] r;
    r = v;
    if (v < lo) r = lo;
    else if (v > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR, taps 8,6,5,4.
// Free-running; a non-zero seed keeps it off zero.
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q
);

  logic fb;

  assign fb = q[7] ^ q[5] ^ q[4] ^ q[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= SEED;
    else     q <= {q[6:0], fb};
  end

endmodule

// File: rtl/pipe_control.sv
// pipe_control: scrolls one pipe leftward per frame,
// reloads it with a random hole and flags bird passes.
module pipe_control
  import flappy_pkg::*;
#(
  parameter int         SCREEN_WIDTH = SCREEN_W,
  parameter int         SCROLL_STEP  = 1,
  parameter int         BIRD_X       = 60,
  parameter int         Y_MIN        = 20,
  parameter int         Y_MAX        = 190,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       FRAME_TICK,
  input  logic       START,
  input  logic       HALT,
  output logic [8:0] PIPE_X_POSITION,
  output logic [7:0] PIPE_Y_HOLE_POSITION,
  output logic       PIPE_PASSED,
  output logic       RUNNING
);

  localparam logic [8:0] X_LOAD = 9'(SCREEN_WIDTH);
  localparam logic [8:0] STEP   = 9'(SCROLL_STEP);
  localparam logic [8:0] BIRD   = 9'(BIRD_X);
  localparam logic [7:0] Y_LO   = 8'(Y_MIN);
  localparam logic [7:0] Y_HI   = 8'(Y_MAX);

  pipe_state_e state_q, state_d;
  logic [8:0]  x_q, x_d;
  logic [7:0]  hole_q, hole_d;
  logic        passed_q, passed_d;
  logic        running_q;
  logic [7:0]  lfsr_q;
  logic [7:0]  hole_new;

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (CLK),
    .rst (RESET),
    .q   (lfsr_q)
  );

  assign hole_new = clamp8(lfsr_q, Y_LO, Y_HI);

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    hole_d   = hole_q;
    passed_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        x_d = X_LOAD;
        if (START) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (HALT) begin
          state_d = ST_STOPPED;
        end else if (FRAME_TICK) begin
          if (x_q >= STEP) begin
            x_d      = x_q - STEP;
            passed_d = (x_q >= BIRD) && (x_d < BIRD);
          end else begin
            // wrap: reload at the right edge, new hole
            x_d    = X_LOAD;
            hole_d = hole_new;
          end
        end
      end
      ST_STOPPED: begin
        if (START && !HALT) begin
          state_d = ST_RUN;
          x_d     = X_LOAD;
          hole_d  = hole_new;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      x_q       <= X_LOAD;
      hole_q    <= Y_LO;
      passed_q  <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      hole_q    <= hole_d;
      passed_q  <= passed_d;
      running_q <= (state_d == ST_RUN);
    end
  end

  assign PIPE_X_POSITION      = x_q;
  assign PIPE_Y_HOLE_POSITION = hole_q;
  assign PIPE_PASSED          = passed_q;
  assign RUNNING              = running_q;

endmodule

// File: tb/tb_pipe_control.sv
// tb_pipe_control: directed stimulus, frame-level
// reference model and per-cycle output comparison.
module tb_pipe_control;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       FRAME_TICK = 1'b0;
  logic       START = 1'b0;
  logic       HALT = 1'b0;
  logic [8:0] PIPE_X_POSITION;
  logic [7:0] PIPE_Y_HOLE_POSITION;
  logic       PIPE_PASSED;
  logic       RUNNING;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;
  int wraps = 0;

  always #5 CLK = ~CLK;

  pipe_control dut (
    .CLK                  (CLK),
    .RESET                (RESET),
    .FRAME_TICK           (FRAME_TICK),
    .START                (START),
    .HALT                 (HALT),
    .PIPE_X_POSITION      (PIPE_X_POSITION),
    .PIPE_Y_HOLE_POSITION (PIPE_Y_HOLE_POSITION),
    .PIPE_PASSED          (PIPE_PASSED),
    .RUNNING              (RUNNING)
  );

  // model: mode 0 idle, 1 run, 2 stopped
  int         m_mode;
  int         m_x;
  int         m_hole;
  logic       m_pass;
  logic [7:0] m_lfsr;

  function automatic logic [7:0] step_lfsr(
    input logic [7:0] v
  );
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  function automatic int clamp(input int v);
    if (v < 20) return 20;
    if (v > 190) return 190;
    return v;
  endfunction

  always @(posedge CLK or posedge RESET) begin
    int   nm, nx, nh;
    logic np;
    if (RESET) begin
      m_mode <= 0;
      m_x    <= 320;
      m_hole <= 20;
      m_pass <= 1'b0;
      m_lfsr <= 8'hA5;
    end else begin
      nm = m_mode;
      nx = m_x;
      nh = m_hole;
      np = 1'b0;
      if (m_mode == 0) begin
        nx = 320;
        if (START) nm = 1;
      end else if (m_mode == 1) begin
        if (HALT) nm = 2;
        else if (FRAME_TICK) begin
          if (m_x >= 1) begin
            nx = m_x - 1;
            np = (m_x >= 60) && (nx < 60);
          end else begin
            nx = 320;
            nh = clamp(int'(m_lfsr));
          end
        end
      end else begin
        if (START && !HALT) begin
          nm = 1;
          nx = 320;
          nh = clamp(int'(m_lfsr));
        end
      end
      m_mode <= nm;
      m_x    <= nx;
      m_hole <= nh;
      m_pass <= np;
      m_lfsr <= step_lfsr(m_lfsr);
    end
  end

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d",
               nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!RESET && chk_on) begin
      chk("x", 32'(PIPE_X_POSITION), m_x);
      chk("hole", 32'(PIPE_Y_HOLE_POSITION), m_hole);
      chk("passed", 32'(PIPE_PASSED), 32'(m_pass));
      chk("running", 32'(RUNNING), 32'(m_mode == 1));
      chk("lfsr", 32'(dut.lfsr_q), 32'(m_lfsr));
      chk("lfsr_nonzero", 32'(dut.lfsr_q != 8'd0), 1);
      chk("hole_range",
          32'(PIPE_Y_HOLE_POSITION >= 8'd20 &&
              PIPE_Y_HOLE_POSITION <= 8'd190), 1);
    end
  end

  task automatic cyc(input logic t, s, h);
    FRAME_TICK = t;
    START      = s;
    HALT       = h;
    @(negedge CLK);
  endtask

  task automatic tick_at(input logic [7:0] target);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (m_lfsr == target) begin
        found = 1'b1;
        break;
      end
      cyc(0, 0, 0);
    end
    chk("lfsr_target_reached", 32'(found), 1);
    cyc(1, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout actual=running required=done");
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    chk("rst_x", 32'(PIPE_X_POSITION), 320);
    chk("rst_hole", 32'(PIPE_Y_HOLE_POSITION), 20);
    chk("rst_running", 32'(RUNNING), 0);
    chk("rst_passed", 32'(PIPE_PASSED), 0);
    chk_on = 1'b1;

    cyc(0, 1, 0);
    chk("start_running", 32'(RUNNING), 1);
    repeat (10) cyc(1, 0, 0);
    chk("ten_ticks_x", 32'(PIPE_X_POSITION), 310);
    chk("ten_ticks_run", 32'(RUNNING), 1);
    chk("ten_ticks_hole", 32'(PIPE_Y_HOLE_POSITION), 20);

    repeat (249) cyc(1, 0, 0);
    chk("x_61", 32'(PIPE_X_POSITION), 61);
    cyc(1, 0, 0);
    chk("x_60", 32'(PIPE_X_POSITION), 60);
    chk("no_pass_60", 32'(PIPE_PASSED), 0);
    cyc(1, 0, 0);
    chk("x_59", 32'(PIPE_X_POSITION), 59);
    chk("pass_59", 32'(PIPE_PASSED), 1);
    cyc(0, 0, 0);
    chk("pass_one_cycle", 32'(PIPE_PASSED), 0);

    repeat (59) cyc(1, 0, 0);
    chk("x_0", 32'(PIPE_X_POSITION), 0);
    tick_at(8'h05);
    chk("wrap_x", 32'(PIPE_X_POSITION), 320);
    chk("clamp_low", 32'(PIPE_Y_HOLE_POSITION), 20);
    chk("wrap_no_pass", 32'(PIPE_PASSED), 0);
    repeat (320) cyc(1, 0, 0);
    tick_at(8'hF0);
    chk("clamp_high", 32'(PIPE_Y_HOLE_POSITION), 190);
    repeat (320) cyc(1, 0, 0);
    tick_at(8'h64);
    chk("clamp_mid", 32'(PIPE_Y_HOLE_POSITION), 100);

    repeat (5) cyc(1, 0, 0);
    chk("pre_halt_x", 32'(PIPE_X_POSITION), 315);
    cyc(1, 0, 1);
    chk("halt_x", 32'(PIPE_X_POSITION), 315);
    chk("halt_stop", 32'(RUNNING), 0);
    repeat (3) cyc(1, 0, 0);
    chk("stopped_frozen", 32'(PIPE_X_POSITION), 315);
    cyc(0, 1, 1);
    chk("start_halt_stay", 32'(RUNNING), 0);
    cyc(0, 1, 0);
    chk("restart_run", 32'(RUNNING), 1);
    chk("restart_x", 32'(PIPE_X_POSITION), 320);

    repeat (3) cyc(1, 0, 0);
    FRAME_TICK = 1'b0;
    chk("pre_rst_x", 32'(PIPE_X_POSITION), 317);
    @(posedge CLK);
    #2 RESET = 1'b1;
    #1;
    chk("async_x", 32'(PIPE_X_POSITION), 320);
    chk("async_hole", 32'(PIPE_Y_HOLE_POSITION), 20);
    chk("async_run", 32'(RUNNING), 0);
    chk("async_pass", 32'(PIPE_PASSED), 0);
    @(negedge CLK);
    RESET = 1'b0;
    cyc(0, 1, 0);
    chk("first_start", 32'(RUNNING), 1);

    for (int i = 0; i < 120 * 321; i++) begin
      cyc(1, 0, 0);
      if (PIPE_X_POSITION == 9'd320) wraps++;
    end
    chk("wrap_count", 32'(wraps), 120);

    FRAME_TICK = 1'b0;
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
